// File: rtl/i2c_ctrl_pkg.sv
// i2c_ctrl_pkg
//   Shared types for the I2C byte master: command opcodes, response
//   codes, controller state encoding and the quarter-counter width.
package i2c_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2,
    CMD_STOP  = 2'd3
  } i2c_cmd_t;

  typedef enum logic [1:0] {
    RSP_OK       = 2'd0,
    RSP_NACK     = 2'd1,
    RSP_ARB_LOST = 2'd2
  } i2c_rsp_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4,
    ST_RESP  = 3'd5
  } i2c_state_t;

  // Wide enough for the largest legal quarter length (65535 clocks).
  localparam int CNT_W = 16;

endpackage

// File: rtl/i2c_clk_gen.sv
// i2c_clk_gen
//   Quarter-period tick generator. Counts 0..CLK_DIV-1 while enabled and
//   pulses tick_o during the last count of each quarter.
//   Ports:
//     clk, rst  - clock, asynchronous active-high reset
//     en_i      - count enable; when low the counter is cleared so every
//                 command starts on a fresh quarter boundary
//     hold_i    - freeze the counter (clock stretching)
//     tick_o    - quarter ends at the next rising edge of clk
module i2c_clk_gen
  import i2c_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic hold_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (!hold_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !hold_i && (cnt_q == LAST);

endmodule

// File: rtl/i2c_byte_master.sv
// i2c_byte_master
//   Byte-level I2C master. Executes one START / WRITE / READ / STOP command
//   at a time and returns a single-cycle response.
//   Optional feature macro: I2C_CLK_STRETCH_EN (target clock stretching;
//   when undefined scl_i is ignored and timing is fixed).
//   Ports:
//     clk, rst                 - clock, asynchronous active-high reset
//     cmd_valid/cmd_ready      - command handshake (ready only when idle)
//     cmd_op, cmd_data, cmd_ack- opcode, WRITE byte, READ ack choice
//     rsp_valid                - one-cycle completion pulse
//     rsp_data, rsp_status     - READ byte (0 otherwise), OK/NACK/ARB_LOST
//     scl_i, sda_i             - synchronised bus levels
//     scl_oe, sda_oe           - 1 pulls the line low, 0 releases it
module i2c_byte_master
  import i2c_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  i2c_cmd_t   cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_ack,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output i2c_rsp_t   rsp_status,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe
);

  i2c_state_t state_q, state_d;
  i2c_cmd_t   op_q, op_d;
  i2c_rsp_t   status_q, status_d;
  i2c_rsp_t   rsp_status_q, rsp_status_d;
  logic [7:0] data_q, data_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic [1:0] quarter_q, quarter_d;
  logic [2:0] bit_q, bit_d;
  logic       ack_q, ack_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       scl_oe_q, scl_oe_d;
  logic       sda_oe_q, sda_oe_d;

  logic tick, en, hold, accept, arb;

  assign en = (state_q == ST_START) || (state_q == ST_BIT) ||
              (state_q == ST_ACK)   || (state_q == ST_STOP);

`ifdef I2C_CLK_STRETCH_EN
  // Released SCL that reads low means a target is stretching the clock.
  assign hold = en && !scl_oe_q && !scl_i;
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign hold       = 1'b0;
`endif

  i2c_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk   (clk),
    .rst   (rst),
    .en_i  (en),
    .hold_i(hold),
    .tick_o(tick)
  );

  assign accept = cmd_valid && cmd_ready_q;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    status_d     = status_q;
    rsp_status_d = rsp_status_q;
    data_d       = data_q;
    rsp_data_d   = rsp_data_q;
    quarter_d    = quarter_q;
    bit_d        = bit_q;
    ack_d        = ack_q;
    rsp_valid_d  = 1'b0;
    scl_oe_d     = scl_oe_q;
    sda_oe_d     = sda_oe_q;
    arb          = 1'b0;

    // Arbitration: we released SDA during an SCL-high quarter but someone
    // else is holding it low. Only checked where the master owns SDA.
    if (tick && !scl_oe_q && !sda_oe_q && !sda_i &&
        ((state_q == ST_START) || (state_q == ST_STOP) ||
         ((state_q == ST_BIT) && (op_q == CMD_WRITE)))) begin
      arb = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d      = cmd_op;
          ack_d     = cmd_ack;
          data_d    = (cmd_op == CMD_WRITE) ? cmd_data : 8'h00;
          quarter_d = 2'd0;
          bit_d     = 3'd7;
          status_d  = RSP_OK;
          unique case (cmd_op)
            CMD_START: state_d = ST_START;
            CMD_STOP:  state_d = ST_STOP;
            default:   state_d = ST_BIT;
          endcase
        end
      end
      ST_START, ST_STOP: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          if (quarter_q == 2'd3) state_d = ST_RESP;
        end
      end
      ST_BIT: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          if (quarter_q == 2'd3) begin
            // End of the second SCL-high quarter: data is stable here.
            if (op_q == CMD_READ) data_d = {data_q[6:0], sda_i};
            bit_d = bit_q - 3'd1;
            if (bit_q == 3'd0) state_d = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          if (quarter_q == 2'd3) begin
            if ((op_q == CMD_WRITE) && sda_i) status_d = RSP_NACK;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_d      = ST_IDLE;
        rsp_valid_d  = 1'b1;
        rsp_data_d   = (op_q == CMD_READ) ? data_q : 8'h00;
        rsp_status_d = status_q;
      end
      default: state_d = ST_IDLE;
    endcase

    if (arb) begin
      state_d  = ST_RESP;
      status_d = RSP_ARB_LOST;
    end

    // Line drivers follow the phase being entered so they change on the
    // same edge as the quarter boundary. IDLE/RESP keep the bus as left.
    unique case (state_d)
      ST_START: begin
        scl_oe_d = (quarter_d == 2'd3);
        sda_oe_d = (quarter_d != 2'd0);
      end
      ST_BIT: begin
        scl_oe_d = !quarter_d[1];
        sda_oe_d = (op_d == CMD_WRITE) ? !data_d[bit_d] : 1'b0;
      end
      ST_ACK: begin
        scl_oe_d = !quarter_d[1];
        sda_oe_d = (op_d == CMD_READ) ? ack_d : 1'b0;
      end
      ST_STOP: begin
        scl_oe_d = (quarter_d == 2'd0);
        sda_oe_d = !quarter_d[1];
      end
      default: ;
    endcase

    if (arb) begin
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
    end

    // Registered so that ready stays low for the first clock after reset.
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= CMD_START;
      status_q     <= RSP_OK;
      rsp_status_q <= RSP_OK;
      data_q       <= 8'h00;
      rsp_data_q   <= 8'h00;
      quarter_q    <= 2'd0;
      bit_q        <= 3'd0;
      ack_q        <= 1'b0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      scl_oe_q     <= 1'b0;
      sda_oe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      status_q     <= status_d;
      rsp_status_q <= rsp_status_d;
      data_q       <= data_d;
      rsp_data_q   <= rsp_data_d;
      quarter_q    <= quarter_d;
      bit_q        <= bit_d;
      ack_q        <= ack_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      scl_oe_q     <= scl_oe_d;
      sda_oe_q     <= sda_oe_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;
  assign scl_oe     = scl_oe_q;
  assign sda_oe     = sda_oe_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// tb_i2c_byte_master
//   Directed + randomized bench for i2c_byte_master (CLK_DIV = 4) with a
//   timing-window target model and a spec-level expectation model.
module tb_i2c_byte_master;
  import i2c_ctrl_pkg::*;

  localparam int Q     = 4;
  localparam int BIT_T = 4 * Q;
  localparam int LIMIT = 2000;
`ifdef I2C_CLK_STRETCH_EN
  localparam int STRETCH_GAIN = 1;
`else
  localparam int STRETCH_GAIN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  i2c_cmd_t   cmd_op = CMD_START;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ack = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  i2c_rsp_t   rsp_status;
  logic       scl_i, sda_i, scl_oe, sda_oe;

  logic slave_low = 1'b0, force_low = 1'b0, stretch_low = 1'b0;
  assign sda_i = !(sda_oe || slave_low || force_low);
  assign scl_i = !(scl_oe || stretch_low);

  i2c_byte_master #(.CLK_DIV(Q)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_ack(cmd_ack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .scl_i(scl_i), .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Per-command target/stimulus configuration.
  logic       cfg_slave_ack = 1'b0;
  logic [7:0] cfg_slave_byte = 8'h00;
  int         cfg_force_t = -1;
  int         cfg_stretch_t = -1;
  int         cfg_stretch_len = 0;
  int         cfg_probe_t = -1;

  // Observations.
  int         obs_lat;
  logic [7:0] obs_bits;
  int         obs_rd_pull;
  logic       obs_ack_oe;
  logic       obs_probe_scl, obs_probe_sda;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bus quarters per command plus the one-cycle response stage.
  function automatic int model_lat(input i2c_cmd_t op);
    return (((op == CMD_START) || (op == CMD_STOP)) ? 4 : 36) * Q + 1;
  endfunction

  task automatic run_cmd(input string tag, input i2c_cmd_t op,
                         input logic [7:0] data, input logic ack);
    int w, t, b, exp_lat;
    logic arb_exp;
    i2c_rsp_t exp_status, got_status;
    logic [7:0] exp_data, got_data;
    w = 0;
    while (!cmd_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    slave_low = 1'b0; force_low = 1'b0; stretch_low = 1'b0;
    cmd_op = op; cmd_data = data; cmd_ack = ack; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t = 0; obs_bits = 8'h00; obs_rd_pull = 0; obs_ack_oe = 1'bx;
    obs_probe_scl = 1'bx; obs_probe_sda = 1'bx;
    while (!rsp_valid && t < LIMIT) begin
      if ((op == CMD_READ || op == CMD_WRITE) && t < 9 * BIT_T) begin
        b = t / BIT_T;
        if (t % BIT_T == 0) begin
          if (b < 8) slave_low = (op == CMD_READ) ? !cfg_slave_byte[7-b] : 1'b0;
          else       slave_low = (op == CMD_WRITE) ? cfg_slave_ack : 1'b0;
        end
        if (t % BIT_T == 2 * Q) begin
          if (b < 8) obs_bits[7-b] = !sda_oe;
          else       obs_ack_oe = sda_oe;
        end
        if (op == CMD_READ && b < 8 && sda_oe) obs_rd_pull++;
      end
      if (t == cfg_force_t) force_low = 1'b1;
      if (t == cfg_stretch_t) stretch_low = 1'b1;
      if (t == cfg_stretch_t + cfg_stretch_len) stretch_low = 1'b0;
      if (t == cfg_probe_t) begin
        obs_probe_scl = scl_oe; obs_probe_sda = sda_oe;
      end
      @(posedge clk); #1; t++;
    end
    obs_lat = t; got_status = rsp_status; got_data = rsp_data;
    slave_low = 1'b0; force_low = 1'b0; stretch_low = 1'b0;

    arb_exp = (cfg_force_t >= 0);
    if (arb_exp) exp_lat = ((cfg_force_t / Q) + 1) * Q + 1;
    else exp_lat = model_lat(op) + ((cfg_stretch_t >= 0) ? cfg_stretch_len * STRETCH_GAIN : 0);
    if (arb_exp) exp_status = RSP_ARB_LOST;
    else if (op == CMD_WRITE && !cfg_slave_ack) exp_status = RSP_NACK;
    else exp_status = RSP_OK;
    exp_data = (op == CMD_READ) ? cfg_slave_byte : 8'h00;

    $display("TXN %s op=%s data=%02h ack=%0b lat=%0d status=%s rdata=%02h",
             tag, op.name(), data, ack, obs_lat, got_status.name(), got_data);
    chk({tag, "_lat"}, 32'(obs_lat), 32'(exp_lat));
    chk({tag, "_status"}, 32'(got_status), 32'(exp_status));
    chk({tag, "_rdata"}, 32'(got_data), 32'(exp_data));
    if (op == CMD_WRITE && !arb_exp && cfg_stretch_t < 0)
      chk({tag, "_sda_bits"}, 32'(obs_bits), 32'(data));
    if (op == CMD_READ) begin
      chk({tag, "_rd_pull"}, 32'(obs_rd_pull), 32'd0);
      chk({tag, "_ack_oe"}, 32'(obs_ack_oe), 32'(ack));
    end
    if (cfg_probe_t >= 0) begin
      chk({tag, "_arb_scl_oe"}, 32'(obs_probe_scl), 32'd0);
      chk({tag, "_arb_sda_oe"}, 32'(obs_probe_sda), 32'd0);
    end
    @(posedge clk); #1;
    chk({tag, "_pulse_1cyc"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_scl_oe"}, 32'(scl_oe), 32'd0);
    chk({tag, "_sda_oe"}, 32'(sda_oe), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({tag, "_rsp_status"}, 32'(rsp_status), 32'(RSP_OK));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset.
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;
    #1 chk("por_ready_before_edge", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("por_ready_after_edge", 32'(cmd_ready), 32'd1);

    // START then WRITE 0xA4 with target ACK.
    run_cmd("start0", CMD_START, 8'h00, 1'b0);
    cfg_slave_ack = 1'b1;
    run_cmd("wr_a4", CMD_WRITE, 8'hA4, 1'b0);
    // WRITE 0x55, target leaves SDA high on ACK.
    cfg_slave_ack = 1'b0;
    run_cmd("wr_55_nack", CMD_WRITE, 8'h55, 1'b0);
    // READ 0x3C answered with NACK.
    cfg_slave_byte = 8'h3C;
    run_cmd("rd_3c", CMD_READ, 8'h00, 1'b0);

    // Randomized commands.
    for (int i = 0; i < 10; i++) begin
      i2c_cmd_t op;
      op = i2c_cmd_t'($urandom_range(0, 3));
      cfg_slave_ack  = 1'($urandom_range(0, 1));
      cfg_slave_byte = 8'($urandom);
      run_cmd($sformatf("rnd%0d", i), op, 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // STOP leaves the bus released.
    run_cmd("stop0", CMD_STOP, 8'h00, 1'b0);
    chk("stop0_scl_released", 32'(scl_oe), 32'd0);
    chk("stop0_sda_released", 32'(sda_oe), 32'd0);

    // Arbitration loss: SDA forced low in the 4th data bit's first high quarter.
    run_cmd("start1", CMD_START, 8'h00, 1'b0);
    cfg_force_t = 3 * BIT_T + 2 * Q;
    cfg_probe_t = ((cfg_force_t / Q) + 1) * Q;
    run_cmd("wr_ff_arb", CMD_WRITE, 8'hFF, 1'b0);
    cfg_force_t = -1; cfg_probe_t = -1;

    // Reset in quarter 20 of a WRITE, with a nonzero response held.
    cfg_slave_byte = 8'h3C;
    run_cmd("rd_3c_b", CMD_READ, 8'h00, 1'b1);
    chk("pre_rst_rsp_data", 32'(rsp_data), 32'h3C);
    cmd_op = CMD_WRITE; cmd_data = 8'h00; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (20 * Q) @(posedge clk);
    #1;
    chk("mid_scl_oe_active", 32'(scl_oe), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    chk("midrst_ready_held", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1 chk("midrst_ready_before_edge", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("midrst_ready_after_edge", 32'(cmd_ready), 32'd1);

    // Clock stretching in bit 0's first SCL-high quarter.
    run_cmd("start2", CMD_START, 8'h00, 1'b0);
    cfg_slave_ack = 1'b0;
    cfg_stretch_t = 2 * Q; cfg_stretch_len = 50;
    run_cmd("wr_stretch", CMD_WRITE, 8'h5A, 1'b0);
    cfg_stretch_t = -1; cfg_stretch_len = 0;
    run_cmd("stop1", CMD_STOP, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
